// File: rtl/bsram_sp_banked.sv
// Banked single-port block RAM with byte-lane writes, selectable write
// response mode, optional output register and a response-valid strobe.
module bsram_sp_banked #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 15,
  parameter int unsigned BANK_ADDR_W = 14,
  parameter int unsigned OUT_REG     = 0,
  parameter int unsigned WRITE_MODE  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [DATA_W/8-1:0]   req_be,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata
);

  localparam int unsigned BE_W       = DATA_W / 8;
  localparam int unsigned BANK_W     = ADDR_W - BANK_ADDR_W;
  localparam int unsigned NBANK      = 1 << BANK_W;
  localparam int unsigned BANK_DEPTH = 1 << BANK_ADDR_W;
  // Keep the bank index at least one bit wide for the single-bank case.
  localparam int unsigned IDX_W      = (BANK_W > 0) ? BANK_W : 1;

  logic [IDX_W-1:0]       req_bank;
  logic [BANK_ADDR_W-1:0] req_word;
  logic                   accept;
  logic                   rsp_gen;

  logic [DATA_W-1:0]      bank_rd [NBANK];
  logic                   s1_valid_q;
  logic [IDX_W-1:0]       s1_bank_q;
  logic [DATA_W-1:0]      s1_rdata;

  assign req_word = req_addr[BANK_ADDR_W-1:0];
  assign accept   = ce && req_valid;
  // Reads always respond; writes respond only in write-through or read-before-write mode.
  assign rsp_gen  = accept && (!req_we || (WRITE_MODE != 0));

  if (BANK_W > 0) begin : g_multi_bank
    assign req_bank = req_addr[ADDR_W-1:BANK_ADDR_W];
  end else begin : g_single_bank
    assign req_bank = '0;
  end

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    logic [DATA_W-1:0] mem [BANK_DEPTH];
    logic [DATA_W-1:0] rd_q;
    logic              sel;

    assign sel        = (req_bank == IDX_W'(b));
    assign bank_rd[b] = rd_q;

    // Bank array access: read/write port plus the bank's stage-1 read register.
    // The array itself is never reset; only the read register is cleared.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rd_q <= '0;
      end else if (accept && sel) begin
        if (!req_we) begin
          rd_q <= mem[req_word];
        end else begin
          if (WRITE_MODE == 1) begin
            rd_q <= req_wdata;
          end else if (WRITE_MODE == 2) begin
            rd_q <= mem[req_word];
          end
          for (int i = 0; i < BE_W; i++) begin
            if (req_be[i]) begin
              mem[req_word][8*i +: 8] <= req_wdata[8*i +: 8];
            end
          end
        end
      end
    end
  end

  // Stage 1 control: response flag and the bank index that steers the output mux.
  // The index only moves with a response, so the mux keeps showing the last result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_bank_q  <= '0;
    end else if (ce) begin
      s1_valid_q <= rsp_gen;
      if (rsp_gen) begin
        s1_bank_q <= req_bank;
      end
    end
  end

  assign s1_rdata = bank_rd[s1_bank_q];

  if (OUT_REG != 0) begin : g_out_reg
    logic              s2_valid_q;
    logic [DATA_W-1:0] s2_rdata_q;

    // Stage 2: straight copy of stage 1 on every enabled cycle.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        s2_valid_q <= 1'b0;
        s2_rdata_q <= '0;
      end else if (ce) begin
        s2_valid_q <= s1_valid_q;
        s2_rdata_q <= s1_rdata;
      end
    end

    assign rsp_valid = s2_valid_q;
    assign rsp_rdata = s2_rdata_q;
  end else begin : g_no_out_reg
    assign rsp_valid = s1_valid_q;
    assign rsp_rdata = s1_rdata;
  end

endmodule

// File: tb/tb_bsram_sp_banked.sv
// Bench for bsram_sp_banked: three parameterisations share one stimulus stream
// and are checked every cycle against a response-schedule model, plus literal checks.
module tb_bsram_sp_banked;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic        req_valid;
  logic        req_we;
  logic [3:0]  req_be;
  logic [5:0]  req_addr;
  logic [31:0] req_wdata;
  logic        v0, v1, v2;
  logic [31:0] d0, d1, d2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // u0: 4 banks, latency 1, read-before-write
  bsram_sp_banked #(.DATA_W(32), .ADDR_W(6), .BANK_ADDR_W(4), .OUT_REG(0), .WRITE_MODE(2)) u0 (
    .clk(clk), .reset(reset), .ce(ce), .req_valid(req_valid), .req_we(req_we),
    .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(v0), .rsp_rdata(d0)
  );
  // u1: 4 banks, latency 2, write-through
  bsram_sp_banked #(.DATA_W(32), .ADDR_W(6), .BANK_ADDR_W(4), .OUT_REG(1), .WRITE_MODE(1)) u1 (
    .clk(clk), .reset(reset), .ce(ce), .req_valid(req_valid), .req_we(req_we),
    .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(v1), .rsp_rdata(d1)
  );
  // u2: single bank, latency 1, no write response
  bsram_sp_banked #(.DATA_W(32), .ADDR_W(6), .BANK_ADDR_W(6), .OUT_REG(0), .WRITE_MODE(0)) u2 (
    .clk(clk), .reset(reset), .ce(ce), .req_valid(req_valid), .req_we(req_we),
    .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(v2), .rsp_rdata(d2)
  );

  function automatic int lat(input int d);
    return (d == 1) ? 2 : 1;
  endfunction

  function automatic int wmode(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 1 : 0);
  endfunction

  // Model: word array plus a schedule of responses keyed by enabled-cycle count.
  // Entry bit 32 says whether the data is known (full-word written).
  logic [31:0] ref_mem   [64];
  bit          ref_known [64];
  logic [32:0] exp_map   [int];
  logic [32:0] last_d    [3];
  int          ecnt = 0;

  initial begin
    for (int i = 0; i < 64; i++) ref_known[i] = 1'b0;
    for (int d = 0; d < 3; d++) last_d[d] = {1'b1, 32'h0};
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_map.delete();
      for (int d = 0; d < 3; d++) last_d[d] = {1'b1, 32'h0};
    end else if (ce) begin
      for (int d = 0; d < 3; d++) begin
        if (exp_map.exists(ecnt*4 + d)) last_d[d] = exp_map[ecnt*4 + d];
      end
      if (req_valid) begin
        for (int d = 0; d < 3; d++) begin
          if (!req_we || wmode(d) == 2)
            exp_map[(ecnt + lat(d))*4 + d] = {ref_known[req_addr], ref_mem[req_addr]};
          else if (wmode(d) == 1)
            exp_map[(ecnt + lat(d))*4 + d] = {1'b1, req_wdata};
        end
        if (req_we) begin
          for (int i = 0; i < 4; i++)
            if (req_be[i]) ref_mem[req_addr][8*i +: 8] = req_wdata[8*i +: 8];
          if (req_be == 4'hF) ref_known[req_addr] = 1'b1;
        end
      end
      ecnt++;
    end
  end

  task automatic cmp(input int d, input logic v, input logic [31:0] r);
    logic        ev;
    logic [32:0] e;
    if (exp_map.exists(ecnt*4 + d)) begin
      ev = 1'b1;
      e  = exp_map[ecnt*4 + d];
    end else begin
      ev = 1'b0;
      e  = last_d[d];
    end
    checks++;
    if (v !== ev || (e[32] && r !== e[31:0])) begin
      errors++;
      $display("FAIL model u%0d t=%0t: got valid=%0b data=%h, need valid=%0b data=%h",
               d, $time, v, r, ev, e[31:0]);
    end
  endtask

  always @(negedge clk) begin
    cmp(0, v0, d0);
    cmp(1, v1, d1);
    cmp(2, v2, d2);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, need %h", name, act, exp);
    end
  endtask

  // Drive one request just after a negedge; return at the next negedge.
  task automatic cyc(input logic v, input logic we, input logic [3:0] be,
                     input logic [5:0] a, input logic [31:0] w);
    req_valid = v;
    req_we    = we;
    req_be    = be;
    req_addr  = a;
    req_wdata = w;
    @(negedge clk);
  endtask

  logic [5:0] ra;

  initial begin
    reset = 1'b1;
    ce = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_be = 4'h0; req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    chk("reset valid u0", {31'b0, v0}, 32'h0);
    chk("reset data u1", d1, 32'h0);
    reset = 1'b0;

    // Fill the array so every word is known.
    for (int i = 0; i < 64; i++) cyc(1'b1, 1'b1, 4'hF, 6'(i), {8'(i), 8'hC3, 8'(i * 3), 8'h5A});
    cyc(1'b0, 1'b0, 4'h0, 6'h0, 32'h0);

    // Bank isolation
    cyc(1'b1, 1'b1, 4'hF, 6'h00, 32'h0000_00A5);
    cyc(1'b1, 1'b1, 4'hF, 6'h10, 32'h0000_005A);
    cyc(1'b1, 1'b0, 4'h0, 6'h00, 32'h0);
    chk("bank0 read u0", d0, 32'h0000_00A5);
    chk("bank0 read u0 valid", {31'b0, v0}, 32'h1);
    chk("bank0 read u2", d2, 32'h0000_00A5);
    chk("wt resp u1", d1, 32'h0000_005A);
    cyc(1'b1, 1'b0, 4'h0, 6'h10, 32'h0);
    chk("bank1 read u0", d0, 32'h0000_005A);
    chk("bank1 read u2", d2, 32'h0000_005A);
    chk("bank0 read u1 lat2", d1, 32'h0000_00A5);

    // Byte lanes
    cyc(1'b1, 1'b1, 4'hF, 6'd5, 32'h1122_3344);
    cyc(1'b1, 1'b1, 4'b0100, 6'd5, 32'hFFFF_FFFF);
    chk("rbw old word u0", d0, 32'h1122_3344);
    chk("wt first write u1", d1, 32'h1122_3344);
    cyc(1'b1, 1'b0, 4'h0, 6'd5, 32'h0);
    chk("lane merge u0", d0, 32'h11FF_3344);
    chk("lane merge u2", d2, 32'h11FF_3344);
    chk("wt as driven u1", d1, 32'hFFFF_FFFF);
    cyc(1'b0, 1'b0, 4'h0, 6'h0, 32'h0);
    chk("lane merge u1", d1, 32'h11FF_3344);

    // Write modes
    cyc(1'b1, 1'b1, 4'hF, 6'd7, 32'h0000_003C);
    cyc(1'b1, 1'b1, 4'hF, 6'd7, 32'h0000_00C3);
    chk("rbw returns old u0", d0, 32'h0000_003C);
    chk("mode0 no rsp u2", {31'b0, v2}, 32'h0);
    chk("mode0 data held u2", d2, 32'h11FF_3344);
    cyc(1'b1, 1'b0, 4'h0, 6'd7, 32'h0);
    chk("raw new data u0", d0, 32'h0000_00C3);
    chk("wt returns new u1", d1, 32'h0000_00C3);
    cyc(1'b1, 1'b1, 4'h0, 6'd7, 32'hDEAD_BEEF);
    chk("be0 write rsp u0", d0, 32'h0000_00C3);
    cyc(1'b1, 1'b0, 4'h0, 6'd7, 32'h0);
    chk("be0 no change u0", d0, 32'h0000_00C3);
    chk("be0 wt rsp u1", d1, 32'hDEAD_BEEF);

    // ce freeze mid-stream
    cyc(1'b1, 1'b0, 4'h0, 6'd0, 32'h0);
    cyc(1'b1, 1'b0, 4'h0, 6'd1, 32'h0);
    chk("stream u1 first", d1, 32'h0000_00A5);
    ce = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b0, 4'h0, 6'd2, 32'h0);
      chk("freeze u1 valid", {31'b0, v1}, 32'h1);
      chk("freeze u1 data", d1, 32'h0000_00A5);
    end
    ce = 1'b1;
    cyc(1'b1, 1'b0, 4'h0, 6'd2, 32'h0);
    cyc(1'b0, 1'b0, 4'h0, 6'd0, 32'h0);
    cyc(1'b0, 1'b0, 4'h0, 6'd0, 32'h0);

    // Reset with reads in flight
    cyc(1'b1, 1'b0, 4'h0, 6'h10, 32'h0);
    req_addr = 6'd5;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async rst v0", {31'b0, v0}, 32'h0);
    chk("async rst d0", d0, 32'h0);
    chk("async rst v1", {31'b0, v1}, 32'h0);
    chk("async rst d1", d1, 32'h0);
    chk("async rst d2", d2, 32'h0);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) cyc(1'b0, 1'b0, 4'h0, 6'd0, 32'h0);
    cyc(1'b1, 1'b0, 4'h0, 6'd5, 32'h0);
    chk("mem kept u0", d0, 32'h11FF_3344);
    cyc(1'b0, 1'b0, 4'h0, 6'd0, 32'h0);
    chk("mem kept u1", d1, 32'h11FF_3344);

    // Random traffic
    ra = 6'd0;
    for (int n = 0; n < 2000; n++) begin
      ce = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 3) != 0) ra = 6'($urandom_range(0, 63));
      cyc(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
          ra, $urandom);
    end
    ce = 1'b1;
    repeat (4) cyc(1'b0, 1'b0, 4'h0, 6'd0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
